uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one UART transmitter between N_REQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// Grants a requester, drives the send_req/d_in handshake, reports done or timeout.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     done,
    output logic                 err_timeout,
    output logic                 busy,
    output logic [IDW-1:0]       cur_id,
    output logic                 send_req,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               send_q, send_d;

    logic               found;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     nxt_id;

    // First pending request at or after ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign nxt_id = (int'(cur_id_q) == N_REQ - 1) ? '0 : cur_id_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cur_id_d  = cur_id_q;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        send_d    = send_q;
        unique case (state_q)
            IDLE: begin
                if (enable && tx_ready && found) begin
                    tx_data_d  = req_data[8*win +: 8];
                    cur_id_d   = win;
                    ack_d[win] = 1'b1;
                    send_d     = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (!tx_ready) begin
                    send_d  = 1'b0;
                    state_d = BUSY;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    send_d  = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = nxt_id;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (tx_ready) begin
                    done_d[cur_id_q] = 1'b1;
                    busy_d           = 1'b0;
                    ptr_d            = nxt_id;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            cur_id_q  <= '0;
            tx_data_q <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            send_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            cur_id_q  <= cur_id_d;
            tx_data_q <= tx_data_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            send_q    <= send_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign busy        = busy_q;
    assign cur_id      = cur_id_q;
    assign send_req    = send_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus
// multi-cycle sequences against a small UART Tx handshake model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        err_timeout;
    logic        busy;
    logic [1:0]  cur_id;
    logic        send_req;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    int total = 0;
    int bad = 0;

    logic model_on = 1'b0;
    logic forced_ready = 1'b1;
    int   frame_cnt = 0;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req),
        .req_data(req_data), .ack(ack), .done(done),
        .err_timeout(err_timeout), .busy(busy), .cur_id(cur_id),
        .send_req(send_req), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Tx model: accepts send_req one cycle later, then stays busy for 3 cycles.
    always @(negedge clk) begin
        if (!model_on) begin
            tx_ready = forced_ready;
            frame_cnt = 0;
        end else if (frame_cnt > 0) begin
            frame_cnt = frame_cnt - 1;
            if (frame_cnt == 0) tx_ready = 1'b1;
        end else if (send_req && tx_ready) begin
            tx_ready = 1'b0;
            frame_cnt = 3;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("pulse_excl", 32'($onehot0({ack, done, err_timeout})), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int id, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        id = -1;
        d = '0;
        for (int n = 0; n < 100 && !ok; n++) begin
            step();
            if (ack != 0) begin
                ok = 1'b1;
                d = tx_data;
                for (int b = 0; b < 4; b++) if (ack[b]) id = b;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  req;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  ack;
        logic [3:0]  done;
        logic        send;
        logic        busy;
        logic        err;
        logic [7:0]  txd;
        logic [1:0]  id;
    } vec_t;

    localparam logic [31:0] D = 32'h33A5113C;
    vec_t tbl[14];

    initial begin
        int id;
        logic [7:0] d;
        bit ok;
        int n;

        tbl[0]  = '{1, 0, 4'b0000, D,     1, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{0, 1, 4'b0100, D,     1, 4'b0100, 4'b0000, 1, 1, 0, 8'hA5, 2};
        tbl[2]  = '{0, 1, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 0, 1, 0, 8'hA5, 2};
        tbl[3]  = '{0, 1, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 0, 1, 0, 8'hA5, 2};
        tbl[4]  = '{0, 1, 4'b0001, D,     1, 4'b0000, 4'b0100, 0, 0, 0, 8'hA5, 2};
        tbl[5]  = '{0, 1, 4'b0001, D,     1, 4'b0001, 4'b0000, 1, 1, 0, 8'h3C, 0};
        tbl[6]  = '{0, 1, 4'b1010, D,     0, 4'b0000, 4'b0000, 0, 1, 0, 8'h3C, 0};
        tbl[7]  = '{0, 1, 4'b1010, D,     1, 4'b0000, 4'b0001, 0, 0, 0, 8'h3C, 0};
        tbl[8]  = '{0, 1, 4'b1010, D,     1, 4'b0010, 4'b0000, 1, 1, 0, 8'h11, 1};
        tbl[9]  = '{0, 1, 4'b1000, D,     0, 4'b0000, 4'b0000, 0, 1, 0, 8'h11, 1};
        tbl[10] = '{1, 1, 4'b1000, D,     0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0};
        tbl[11] = '{0, 1, 4'b1001, D,     0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0};
        tbl[12] = '{0, 0, 4'b1001, D,     1, 4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0};
        tbl[13] = '{0, 1, 4'b1001, D,     1, 4'b0001, 4'b0000, 1, 1, 0, 8'h3C, 0};

        #1;
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst;
            enable = tbl[i].en;
            req = tbl[i].req;
            req_data = tbl[i].data;
            forced_ready = tbl[i].rdy;
            step();
            check($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].ack));
            check($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("v%0d send", i), 32'(send_req), 32'(tbl[i].send));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("v%0d err", i), 32'(err_timeout), 32'(tbl[i].err));
            check($sformatf("v%0d txd", i), 32'(tx_data), 32'(tbl[i].txd));
            check($sformatf("v%0d id", i), 32'(cur_id), 32'(tbl[i].id));
        end

        // Full round robin with all requesters pending.
        do_reset();
        model_on = 1'b1;
        enable = 1'b1;
        req_data = 32'h13121110;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(id, d, ok);
            check($sformatf("rr%0d seen", k), 32'(ok), 32'd1);
            check($sformatf("rr%0d id", k), 32'(id), 32'(k % 4));
            check($sformatf("rr%0d data", k), 32'(d), 32'h10 + 32'(k % 4));
        end

        // Only 1 and 3 pending: strict alternation.
        do_reset();
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_ack(id, d, ok);
            check($sformatf("alt%0d seen", k), 32'(ok), 32'd1);
            check($sformatf("alt%0d id", k), 32'(id), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Transmitter never accepts: timeout after 16 cycles of send_req.
        model_on = 1'b0;
        forced_ready = 1'b1;
        do_reset();
        req = 4'b0100;
        step();
        check("to ack", 32'(ack), 32'b0100);
        req = 4'b0000;
        n = 0;
        while (send_req && n < 40) begin
            n++;
            step();
        end
        check("to send cycles", 32'(n), 32'd16);
        check("to err", 32'(err_timeout), 32'd1);
        check("to busy", 32'(busy), 32'd0);
        check("to send low", 32'(send_req), 32'd0);
        req = 4'b1111;
        step();
        check("to next ack", 32'(ack), 32'b1000);
        req = 4'b0000;
        while (send_req && n < 80) begin
            n++;
            step();
        end

        // enable gating in IDLE, no effect in BUSY.
        do_reset();
        enable = 1'b0;
        req = 4'b0001;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (ack != 0) n++;
        end
        check("en0 no ack", 32'(n), 32'd0);
        enable = 1'b1;
        step();
        check("en1 ack", 32'(ack), 32'b0001);
        req = 4'b0000;
        model_on = 1'b1;
        step();
        enable = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            step();
            if (done != 0) ok = 1'b1;
        end
        check("en0 busy done seen", 32'(ok), 32'd1);
        check("en0 busy done id", 32'(done), 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
